// File: rtl/phim8_onehot_if.sv
// Key conditioner bus: raw key lines in, accepted one-hot key and strobes out.
// The conditioner owns the master side; the key source / encoder owns the slave side.
interface phim8_onehot_if;
  logic [7:0] btn;
  logic [7:0] onehot;
  logic       press_pulse;
  logic       release_pulse;
  logic       held;

  modport master (
    input  btn,
    output onehot,
    output press_pulse,
    output release_pulse,
    output held
  );

  modport slave (
    output btn,
    input  onehot,
    input  press_pulse,
    input  release_pulse,
    input  held
  );
endinterface

// File: rtl/phim8_onehot.sv
// Eight-key synchroniser/debouncer feeding an 8-to-3 encoder.
// Only a single stable key is ever presented as a one-hot code.
module phim8_onehot #(
  parameter int DEB_CYCLES = 16
) (
  input logic            clk,
  input logic            rst_n,
  phim8_onehot_if.master bus
);

  localparam int CW = $clog2(DEB_CYCLES + 1);
  localparam logic [CW-1:0] DEB_MAX = CW'(DEB_CYCLES);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DEBOUNCE,
    S_HOLD,
    S_RELEASE
  } state_t;

  state_t        state;
  logic [7:0]    q1;
  logic [7:0]    s;
  logic [7:0]    cand;
  logic [CW-1:0] cnt;
  logic [7:0]    onehot_q;
  logic          press_q;
  logic          release_q;
  logic          s_onehot;
  logic          s_zero;

  assign s_zero   = (s == 8'h00);
  assign s_onehot = !s_zero && ((s & (s - 8'h01)) == 8'h00);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      q1        <= 8'h00;
      s         <= 8'h00;
      cand      <= 8'h00;
      cnt       <= '0;
      onehot_q  <= 8'h00;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      q1        <= bus.btn;
      s         <= q1;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (s_onehot) begin
            cand  <= s;
            cnt   <= CNT_ONE;
            state <= S_DEBOUNCE;
          end
        end
        S_DEBOUNCE: begin
          if (s != cand) begin
            cnt   <= '0;
            state <= S_IDLE;
          end else if (cnt == DEB_MAX) begin
            onehot_q <= cand;
            press_q  <= 1'b1;
            cnt      <= '0;
            state    <= S_HOLD;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        S_HOLD: begin
          // extra or swapped keys are ignored until a full release
          if (s_zero) begin
            cnt   <= CNT_ONE;
            state <= S_RELEASE;
          end
        end
        S_RELEASE: begin
          if (!s_zero) begin
            cnt   <= '0;
            state <= S_HOLD;
          end else if (cnt == DEB_MAX) begin
            onehot_q  <= 8'h00;
            release_q <= 1'b1;
            cnt       <= '0;
            state     <= S_IDLE;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.onehot        = onehot_q;
  assign bus.press_pulse   = press_q;
  assign bus.release_pulse = release_q;
  assign bus.held          = (state == S_HOLD) || (state == S_RELEASE);

endmodule

// File: tb/tb_phim8_onehot.sv
// Scoreboard bench for phim8_onehot with DEB_CYCLES=4.
// Expected strobes are queued at drive time and matched as they appear.
module tb_phim8_onehot;

  localparam int DEB = 4;
  localparam int LAT = DEB + 3;

  typedef struct {
    bit         rel;
    logic [7:0] oh;
    int         cyc;
  } ev_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   vectors;
  int   miscompares;
  ev_t  sb[$];

  phim8_onehot_if bus ();

  phim8_onehot #(.DEB_CYCLES(DEB)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got %0h exp %0h @cyc %0d", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [2:0] enc(input logic [7:0] v);
    logic [2:0] y;
    y = 3'd0;
    for (int i = 0; i < 8; i++)
      if (v[i]) y = 3'(i);
    return y;
  endfunction

  task automatic drive(input logic [7:0] v);
    @(negedge clk);
    bus.btn = v;
  endtask

  task automatic expect_ev(input bit rel, input logic [7:0] oh);
    ev_t e;
    e.rel = rel;
    e.oh  = oh;
    e.cyc = cyc + LAT;
    sb.push_back(e);
  endtask

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input logic [7:0] v);
    drive(v);
    expect_ev(1'b0, v);
    wait_n(LAT + 2);
  endtask

  task automatic release_all();
    drive(8'h00);
    expect_ev(1'b1, 8'h00);
    wait_n(LAT + 2);
  endtask

  always @(negedge clk) begin
    ev_t e;
    if (rst_n) begin
      chk("inv_onehot", 32'($countones(bus.onehot) <= 1), 32'd1);
      if (bus.press_pulse || bus.release_pulse) begin
        chk("excl", 32'(bus.press_pulse && bus.release_pulse), 32'd0);
        if (sb.size() == 0) begin
          chk("spurious", {bus.release_pulse, bus.press_pulse}, 32'd0);
        end else begin
          e = sb.pop_front();
          chk("kind", 32'(bus.release_pulse), 32'(e.rel));
          chk("cyc", cyc, e.cyc);
          chk("oh", bus.onehot, e.oh);
        end
      end else if (sb.size() > 0 && cyc > sb[0].cyc) begin
        e = sb.pop_front();
        chk("late", {bus.release_pulse, bus.press_pulse},
            e.rel ? 32'd2 : 32'd1);
      end
    end
  end

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    bus.btn     = 8'h00;
    #12;
    chk("rst_oh", bus.onehot, 8'h00);
    chk("rst_held", bus.held, 1'b0);
    chk("rst_pp", bus.press_pulse, 1'b0);
    chk("rst_rp", bus.release_pulse, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // reset while held, key kept down must re-qualify
    wait_n(2);
    press(8'h10);
    chk("r_held", bus.held, 1'b1);
    chk("r_oh", bus.onehot, 8'h10);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_oh", bus.onehot, 8'h00);
    chk("ar_held", bus.held, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    expect_ev(1'b0, 8'h10);
    wait_n(LAT + 2);
    chk("rr_oh", bus.onehot, 8'h10);
    release_all();
    chk("rr_rel", bus.held, 1'b0);

    // clean press
    drive(8'h04);
    expect_ev(1'b0, 8'h04);
    wait_n(LAT);
    chk("cp_oh", bus.onehot, 8'h04);
    chk("cp_held", bus.held, 1'b1);
    chk("cp_y", enc(bus.onehot), 3'b010);
    wait_n(20);
    chk("cp_still", bus.onehot, 8'h04);
    release_all();

    // bounce
    drive(8'h04);
    drive(8'h04);
    drive(8'h00);
    press(8'h04);
    chk("b_oh", bus.onehot, 8'h04);
    release_all();

    // multi-key
    drive(8'h05);
    wait_n(20);
    chk("mk_oh", bus.onehot, 8'h00);
    chk("mk_held", bus.held, 1'b0);
    press(8'h01);
    chk("mk_oh1", bus.onehot, 8'h01);
    release_all();

    // extra keys while held
    press(8'h80);
    drive(8'h81);
    wait_n(5);
    drive(8'h01);
    wait_n(5);
    chk("hx_oh", bus.onehot, 8'h80);
    chk("hx_held", bus.held, 1'b1);
    release_all();
    chk("hx_rel_oh", bus.onehot, 8'h00);
    chk("hx_rel_held", bus.held, 1'b0);

    // release glitch at cnt=2
    press(8'h02);
    drive(8'h00);
    drive(8'h00);
    drive(8'h02);
    drive(8'h00);
    expect_ev(1'b1, 8'h00);
    wait_n(3);
    chk("rg_oh", bus.onehot, 8'h02);
    chk("rg_held", bus.held, 1'b1);
    wait_n(LAT);
    chk("rg_rel", bus.onehot, 8'h00);

    wait_n(10);
    chk("sb_empty", sb.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
